// File: rtl/icache_refill_unit.sv
// Instruction-cache line refill: one AXI read burst per miss, with early-restart
// forwarding of the first beat and abort (flush) handling that drains the burst.
module icache_refill_unit #(
    parameter int BLOCK_SIZE     = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int PALEN          = 32,
    parameter int WRAP_BURST     = 0
) (
    input  logic                        clk,
    input  logic                        a_rst_n,
    input  logic                        abort_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [PALEN-1:0]            req_paddr_i,
    input  logic                        req_uncache_i,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [PALEN-1:0]            ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    output logic                        first_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   first_data_o,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [BLOCK_SIZE*8-1:0]     rsp_line_o,
    output logic                        rsp_uncache_o,
    output logic                        rsp_err_o
);
    localparam int BEATS = BLOCK_SIZE * 8 / AXI_DATA_WIDTH;
    localparam int BOFS  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int LOFS  = $clog2(BLOCK_SIZE);
    localparam int SW    = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, AR, R, DRAIN, RSP} state_t;

    state_t                                r_state;
    logic [PALEN-1:0]                      r_paddr;
    logic                                  r_uncache;
    logic                                  r_err;
    logic                                  r_first;
    logic                                  r_abort_seen;
    logic [SW-1:0]                         r_slot;
    logic [BEATS-1:0][AXI_DATA_WIDTH-1:0]  r_line;
    logic                                  w_rhs;
    logic                                  w_unused;

    assign w_rhs    = r_valid_i & r_ready_o;
    assign w_unused = ^{r_resp_i[0], r_paddr[1:0]};

    assign req_ready_o   = (r_state == IDLE) & ~abort_i;
    assign ar_valid_o    = (r_state == AR);
    assign r_ready_o     = (r_state == R) | (r_state == DRAIN);
    assign rsp_valid_o   = (r_state == RSP);
    assign first_valid_o = (r_state == R) & r_first & r_valid_i & ~abort_i;
    assign first_data_o  = r_data_i;
    assign rsp_line_o    = r_line;
    assign rsp_uncache_o = r_uncache;
    assign rsp_err_o     = r_err;

    // AR fields depend only on latched request state, so they stay stable until handshake.
    always_comb begin
        ar_addr_o  = r_paddr & {{(PALEN-LOFS){1'b1}}, {LOFS{1'b0}}};
        ar_len_o   = 8'(BEATS - 1);
        ar_size_o  = 3'(BOFS);
        ar_burst_o = 2'b01;
        if (r_uncache) begin
            ar_addr_o = {r_paddr[PALEN-1:2], 2'b00};
            ar_len_o  = 8'd0;
            ar_size_o = 3'b010;
        end else if (WRAP_BURST != 0) begin
            ar_addr_o  = r_paddr & {{(PALEN-BOFS){1'b1}}, {BOFS{1'b0}}};
            ar_burst_o = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state      <= IDLE;
            r_paddr      <= '0;
            r_uncache    <= 1'b0;
            r_err        <= 1'b0;
            r_first      <= 1'b0;
            r_abort_seen <= 1'b0;
            r_slot       <= '0;
            r_line       <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_i && req_ready_o) begin
                    r_paddr      <= req_paddr_i;
                    r_uncache    <= req_uncache_i;
                    r_err        <= 1'b0;
                    r_abort_seen <= 1'b0;
                    // Critical-word-first: the wrap burst returns the missed word first.
                    r_slot       <= (WRAP_BURST != 0 && !req_uncache_i) ?
                                    req_paddr_i[LOFS-1:BOFS] : '0;
                    r_state      <= AR;
                end
                AR: begin
                    if (abort_i) r_abort_seen <= 1'b1;
                    if (ar_ready_i) begin
                        r_first <= 1'b1;
                        r_state <= (r_abort_seen || abort_i) ? DRAIN : R;
                    end
                end
                R: begin
                    if (w_rhs) begin
                        r_line[r_slot] <= r_data_i;
                        r_slot         <= r_slot + 1'b1;
                        r_first        <= 1'b0;
                        if (r_resp_i[1]) r_err <= 1'b1;
                        if (r_last_i)     r_state <= abort_i ? IDLE : RSP;
                        else if (abort_i) r_state <= DRAIN;
                    end else if (abort_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: if (w_rhs && r_last_i) r_state <= IDLE;
                RSP:   if (abort_i || rsp_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_unit.sv
// Drives one stimulus stream into an INCR-burst and a WRAP-burst refill unit in
// lockstep and checks both against a per-transfer reference model.
module tb_icache_refill_unit;
    logic         clk, a_rst_n, abort_i;
    logic         req_valid_i, req_uncache_i;
    logic [31:0]  req_paddr_i;
    logic         ar_ready_i, r_valid_i, r_last_i, rsp_ready_i;
    logic [31:0]  r_data_i;
    logic [1:0]   r_resp_i;

    logic         req_ready_a, ar_valid_a, r_ready_a, first_valid_a, rsp_valid_a, rsp_unc_a, rsp_err_a;
    logic [31:0]  ar_addr_a, first_data_a;
    logic [7:0]   ar_len_a;
    logic [2:0]   ar_size_a;
    logic [1:0]   ar_burst_a;
    logic [127:0] rsp_line_a;
    logic         req_ready_b, ar_valid_b, r_ready_b, first_valid_b, rsp_valid_b, rsp_unc_b, rsp_err_b;
    logic [31:0]  ar_addr_b, first_data_b;
    logic [7:0]   ar_len_b;
    logic [2:0]   ar_size_b;
    logic [1:0]   ar_burst_b;
    logic [127:0] rsp_line_b;

    int checks = 0;
    int errors = 0;

    icache_refill_unit #(.BLOCK_SIZE(16), .AXI_DATA_WIDTH(32), .PALEN(32), .WRAP_BURST(0)) u_incr (
        .clk(clk), .a_rst_n(a_rst_n), .abort_i(abort_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_a), .req_paddr_i(req_paddr_i),
        .req_uncache_i(req_uncache_i), .ar_valid_o(ar_valid_a), .ar_ready_i(ar_ready_i),
        .ar_addr_o(ar_addr_a), .ar_len_o(ar_len_a), .ar_size_o(ar_size_a), .ar_burst_o(ar_burst_a),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_a), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .first_valid_o(first_valid_a), .first_data_o(first_data_a),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_i), .rsp_line_o(rsp_line_a),
        .rsp_uncache_o(rsp_unc_a), .rsp_err_o(rsp_err_a));

    icache_refill_unit #(.BLOCK_SIZE(16), .AXI_DATA_WIDTH(32), .PALEN(32), .WRAP_BURST(1)) u_wrap (
        .clk(clk), .a_rst_n(a_rst_n), .abort_i(abort_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_b), .req_paddr_i(req_paddr_i),
        .req_uncache_i(req_uncache_i), .ar_valid_o(ar_valid_b), .ar_ready_i(ar_ready_i),
        .ar_addr_o(ar_addr_b), .ar_len_o(ar_len_b), .ar_size_o(ar_size_b), .ar_burst_o(ar_burst_b),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_b), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .first_valid_o(first_valid_b), .first_data_o(first_data_b),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_i), .rsp_line_o(rsp_line_b),
        .rsp_uncache_o(rsp_unc_b), .rsp_err_o(rsp_err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AR expectations straight from the address-alignment rules.
    task automatic chk_ar(input logic [31:0] pa, input bit unc);
        chk("ar_valid_a", ar_valid_a, 1);
        chk("ar_valid_b", ar_valid_b, 1);
        chk("ar_addr_a", ar_addr_a, unc ? (pa & 32'hFFFF_FFFC) : (pa & 32'hFFFF_FFF0));
        chk("ar_addr_b", ar_addr_b, pa & 32'hFFFF_FFFC);
        chk("ar_len", {ar_len_a, ar_len_b}, unc ? 16'h0000 : 16'h0303);
        chk("ar_size", {ar_size_a, ar_size_b}, 6'o22);
        chk("ar_burst_a", ar_burst_a, 2'b01);
        chk("ar_burst_b", ar_burst_b, unc ? 2'b01 : 2'b10);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_first"}, {first_valid_a, first_valid_b}, 2'b00);
        chk({tag, "_rsp"}, {rsp_valid_a, rsp_valid_b}, 2'b00);
        chk({tag, "_rready"}, {r_ready_a, r_ready_b}, 2'b11);
    endtask

    // mode: 0 normal, 1 abort in R after 2 beats, 2 abort in AR, 3 abort in RSP, 4 reset mid-R.
    // errb: -1 random responses, -2 all OKAY, >=0 SLVERR on that beat only.
    task automatic xfer(input logic [31:0] pa, input bit unc, input int mode, input int errb);
        logic [31:0]  d[4];
        logic [1:0]   rs[4];
        logic [127:0] la, lb;
        bit           eerr;
        int           nb, ad, rd;
        nb = unc ? 1 : 4;
        eerr = 0;
        la = '0;
        lb = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = $urandom;
            if (errb == -1)      rs[k] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            else if (errb == k)  rs[k] = 2'b10;
            else                 rs[k] = 2'b00;
            if (k < nb) begin
                eerr = eerr | rs[k][1];
                la[k*32 +: 32] = d[k];
                lb[((((pa % 16) / 4) + k) % 4) * 32 +: 32] = d[k];
            end
        end
        if (unc) lb[31:0] = d[0];

        req_valid_i = 1; req_paddr_i = pa; req_uncache_i = unc;
        @(negedge clk);
        chk("req_ready", {req_ready_a, req_ready_b}, 2'b11);
        @(posedge clk); #1;
        req_valid_i = 0; req_paddr_i = $urandom;

        ad = (mode == 2) ? 2 : $urandom_range(0, 2);
        for (int i = 0; i < ad; i++) begin
            abort_i = (mode == 2 && i == 0);
            @(negedge clk);
            chk_ar(pa, unc);
            @(posedge clk); #1;
            abort_i = 0;
        end
        ar_ready_i = 1;
        @(negedge clk);
        chk_ar(pa, unc);
        @(posedge clk); #1;
        ar_ready_i = 0;

        for (int k = 0; k < nb; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk_quiet("gap");
                @(posedge clk); #1;
            end
            if (mode == 1 && k == 2) begin
                abort_i = 1;
                @(negedge clk);
                chk_quiet("abort_r");
                @(posedge clk); #1;
                abort_i = 0;
            end
            r_valid_i = 1; r_data_i = d[k]; r_resp_i = rs[k]; r_last_i = (k == nb - 1);
            @(negedge clk);
            chk("beat_rready", {r_ready_a, r_ready_b}, 2'b11);
            if (k == 0 && mode != 2) begin
                chk("first_valid", {first_valid_a, first_valid_b}, 2'b11);
                chk("first_data_a", first_data_a, d[0]);
                chk("first_data_b", first_data_b, d[0]);
            end else begin
                chk("first_valid_off", {first_valid_a, first_valid_b}, 2'b00);
            end
            @(posedge clk); #1;
            r_valid_i = 0; r_last_i = 0; r_resp_i = 0; r_data_i = $urandom;
            if (mode == 4) begin
                a_rst_n = 0;
                #1;
                chk("rst_outs", {ar_valid_a, r_ready_a, rsp_valid_a, first_valid_a,
                                 ar_valid_b, r_ready_b, rsp_valid_b, first_valid_b}, 8'h00);
                chk("rst_line", rsp_line_a | rsp_line_b, 128'h0);
                @(posedge clk); #1;
                a_rst_n = 1;
                @(negedge clk);
                chk("rst_idle", {req_ready_a, req_ready_b, ar_valid_a, ar_valid_b}, 4'b1100);
                @(posedge clk); #1;
                return;
            end
        end

        if (mode == 0 || mode == 3) begin
            rd = (mode == 3) ? 1 : $urandom_range(0, 3);
            for (int i = 0; i <= rd; i++) begin
                rsp_ready_i = (mode == 0 && i == rd);
                abort_i = (mode == 3 && i == rd);
                @(negedge clk);
                chk("rsp_valid", {rsp_valid_a, rsp_valid_b}, 2'b11);
                chk("rsp_unc", {rsp_unc_a, rsp_unc_b}, {unc, unc});
                chk("rsp_err", {rsp_err_a, rsp_err_b}, {eerr, eerr});
                if (unc) begin
                    chk("line_unc_a", rsp_line_a[31:0], d[0]);
                    chk("line_unc_b", rsp_line_b[31:0], d[0]);
                end else begin
                    chk("line_a", rsp_line_a, la);
                    chk("line_b", rsp_line_b, lb);
                end
                @(posedge clk); #1;
                rsp_ready_i = 0; abort_i = 0;
            end
        end
        @(negedge clk);
        chk("done_idle", {req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b}, 4'b1100);
        @(posedge clk); #1;
    endtask

    initial begin
        a_rst_n = 0; abort_i = 0; req_valid_i = 0; req_uncache_i = 0; req_paddr_i = 0;
        ar_ready_i = 0; r_valid_i = 0; r_last_i = 0; rsp_ready_i = 0; r_data_i = 0; r_resp_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {ar_valid_a, r_ready_a, rsp_valid_a, first_valid_a,
                           ar_valid_b, r_ready_b, rsp_valid_b, first_valid_b}, 8'h00);
        chk("reset_line", rsp_line_a | rsp_line_b, 128'h0);
        @(posedge clk); #1;
        a_rst_n = 1;
        @(negedge clk);
        chk("reset_ready", {req_ready_a, req_ready_b}, 2'b11);
        @(posedge clk); #1;

        // abort in IDLE blocks acceptance and nothing else
        abort_i = 1; req_valid_i = 1; req_paddr_i = 32'h3000_0000;
        @(negedge clk);
        chk("idle_abort_ready", {req_ready_a, req_ready_b}, 2'b00);
        @(posedge clk); #1;
        abort_i = 0; req_valid_i = 0;
        @(negedge clk);
        chk("idle_abort_noar", {ar_valid_a, ar_valid_b, req_ready_a, req_ready_b}, 4'b0011);
        @(posedge clk); #1;

        xfer(32'h1000_0014, 0, 0, -2);
        xfer(32'h1000_0018, 0, 0, -2);
        xfer(32'h2000_0006, 1, 0, -2);
        xfer(32'h1000_0040, 0, 0, 1);
        xfer(32'h1000_0044, 0, 0, -2);
        xfer(32'h1000_0088, 0, 1, -1);
        xfer(32'h1000_00C4, 0, 2, -1);
        xfer(32'h1000_010C, 0, 3, -1);
        xfer(32'h1000_0150, 0, 4, -1);
        for (int n = 0; n < 30; n++) begin
            bit unc;
            int md;
            unc = ($urandom_range(0, 3) == 0);
            md  = $urandom_range(0, 3);
            if (unc && md == 1) md = 0;
            xfer($urandom, unc, md, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- BLOCK_SIZE, 16, cache line bytes; power of 2, 8..64.
- AXI_DATA_WIDTH, 32, R-channel data bits; 32 or 64.
- PALEN, 32, physical address bits.
- WRAP_BURST, 0, 1 = critical-word-first WRAP burst; 0 = line-aligned INCR burst.
- Derived: BEATS = BLOCK_SIZE*8/AXI_DATA_WIDTH (>=2); BOFS = log2(AXI_DATA_WIDTH/8).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk  in  1  clock, all state on rising edge.
- a_rst_n  in  1  reset, asynchronous assert, active-low.
- abort_i  in  1  flush; cancel the current refill.
- req_valid_i / req_ready_o  in/out  1  refill request handshake.
- req_paddr_i  in  PALEN  miss physical address.
- req_uncache_i  in  1  uncached single fetch.
- ar_valid_o / ar_ready_i  out/in  1  AXI AR handshake.
- ar_addr_o  out  PALEN; ar_len_o  out  8; ar_size_o  out  3; ar_burst_o  out  2.
- r_valid_i / r_ready_o  in/out  1; r_data_i  in  AXI_DATA_WIDTH; r_resp_i  in  2; r_last_i  in  1.
- first_valid_o  out  1  one-cycle pulse, first beat of a non-aborted transfer (early restart).
- first_data_o  out  AXI_DATA_WIDTH  data of that beat.
- rsp_valid_o / rsp_ready_i  out/in  1  completed-line handshake.
- rsp_line_o  out  BLOCK_SIZE*8  assembled line, beat k at bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
- rsp_uncache_o  out  1; rsp_err_o  out  1  any beat returned r_resp[1]=1.
REQ-003 Clock port SHALL be clk; reset port SHALL be a_rst_n, asynchronous, active-low.

Function
REQ-004 SHALL implement FSM states IDLE, AR, R, DRAIN, RSP.
REQ-005 req_ready_o SHALL be 1 only in IDLE and only when abort_i=0; acceptance on req_valid_i&req_ready_o latches paddr and uncache, clears err, goes to AR.
REQ-006 Cacheable AR: ar_len = BEATS-1, ar_size = BOFS. WRAP_BURST=0: ar_addr = paddr with low log2(BLOCK_SIZE) bits cleared, burst 2'b01. WRAP_BURST=1: ar_addr = paddr with low BOFS bits cleared, burst 2'b10.
REQ-007 Uncached AR: ar_addr = paddr with bits [1:0] cleared, ar_len=0, ar_size=3'b010, burst 2'b01.
REQ-008 In AR, ar_valid_o SHALL be 1 with all AR fields stable until ar_ready_i; on handshake go to R, or to DRAIN if abort was seen in AR or in the handshake cycle. ar_valid_o SHALL never drop before handshake.
REQ-009 Beat slot counter SHALL start at the paddr line-beat index (WRAP_BURST=1, cacheable) or 0 (otherwise), increment modulo BEATS per r_valid&r_ready, and store r_data_i in that slot.
REQ-010 r_ready_o SHALL be 1 in R and DRAIN, 0 elsewhere.
REQ-011 first_valid_o SHALL pulse for exactly the first R-state beat handshake of each transfer, combinationally with first_data_o = r_data_i.
REQ-012 r_resp_i[1]=1 on any beat SHALL set a sticky err reported on rsp_err_o.
REQ-013 In R, r_last handshake SHALL go to RSP; abort_i=1 in R (including the r_last cycle) SHALL go to DRAIN, or to IDLE if r_last handshakes that cycle.
REQ-014 DRAIN SHALL accept and discard beats; r_last handshake goes to IDLE; no rsp or first pulse.
REQ-015 RSP SHALL hold rsp_valid_o=1 with stable outputs until rsp_ready_i, then go to IDLE; abort_i=1 in RSP SHALL drop rsp_valid_o next cycle and go to IDLE.
REQ-016 Uncached response SHALL place the single beat in slot 0, rsp_uncache_o=1.
REQ-017 abort_i in IDLE SHALL have no effect beyond blocking acceptance.

Reset
REQ-018 a_rst_n=0 SHALL immediately force IDLE; slot counter, err, line buffer to 0; ar_valid_o, r_ready_o, rsp_valid_o, first_valid_o = 0; req_ready_o=1 after release.
REQ-019 Reset mid-burst SHALL abandon the transfer; remaining beats are the interconnect's responsibility.

Verification (BLOCK_SIZE=16, AXI_DATA_WIDTH=32, BEATS=4)
REQ-020 WRAP_BURST=0, paddr 0x1000_0014 cacheable, beats D0..D3 -> ar_addr 0x1000_0010, len 3, size 2, burst 01; rsp_line {D3,D2,D1,D0}; first_data=D0.
REQ-021 WRAP_BURST=1, paddr 0x1000_0018, beats A,B,C,D -> ar_addr 0x1000_0018, burst 10; slots 2,3,0,1 = A,B,C,D; first_valid one cycle with A.
REQ-022 Uncached paddr 0x2000_0006, beat 0xDEAD_BEEF -> ar_addr 0x2000_0004, len 0; rsp_uncache=1, line bits[31:0]=0xDEAD_BEEF.
REQ-023 abort after 2 of 4 beats -> r_ready held 1 until r_last, rsp_valid never 1, req_ready=1 cycle after r_last; abort with ar_ready=0 in AR -> ar_valid held until handshake, then DRAIN.
REQ-024 r_resp=2'b10 on beat 1 -> rsp_err=1; next request's rsp_err=0 with OKAY beats.
REQ-025 rsp_ready=0 for 3 cycles -> rsp_valid and rsp_line stable; reset asserted mid-R -> all outputs 0 same cycle, IDLE after release.
